axi_req_arbiter: RTL and testbench



---
 rtl/axi_req_arbiter_pkg.sv | 29 ++
 rtl/arb_grant_sel.sv | 30 +++
 rtl/axi_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_req_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_req_arbiter_pkg.sv
// Shared types and request codes for the cache-to-AXI-bridge request arbiter.
package axi_req_arbiter_pkg;

    localparam int unsigned REQ_W = 3;

    localparam logic [REQ_W-1:0] REQ_TO_AXI_NONE        = 3'd0;
    localparam logic [REQ_W-1:0] REQ_TO_AXI_LOAD_WORD   = 3'd1;
    localparam logic [REQ_W-1:0] REQ_TO_AXI_LOAD_BLOCK  = 3'd2;
    localparam logic [REQ_W-1:0] REQ_TO_AXI_WRITE_WORD  = 3'd3;
    localparam logic [REQ_W-1:0] REQ_TO_AXI_WRITE_BLOCK = 3'd4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        ARB_M_DCACHE = 1'b0,
        ARB_M_ICACHE = 1'b1
    } arb_master_t;

    // ICache only ever reads; any write code from it is treated as no request.
    function automatic logic icache_req_legal(input logic [REQ_W-1:0] req);
        return (req == REQ_TO_AXI_LOAD_WORD) || (req == REQ_TO_AXI_LOAD_BLOCK);
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Grant selector for the request arbiter.
// ARB_ROUND_ROBIN_EN: alternate on conflicts; otherwise DCache wins conflicts.
module arb_grant_sel
    import axi_req_arbiter_pkg::*;
(
    input  logic        i_valid,
    input  logic        d_valid,
    input  arb_master_t rr_last,
    output arb_master_t grant_c
);

    always_comb begin
        grant_c = ARB_M_DCACHE;
        if (i_valid && !d_valid) begin
            grant_c = ARB_M_ICACHE;
        end else if (i_valid && d_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_c = (rr_last == ARB_M_ICACHE) ? ARB_M_DCACHE : ARB_M_ICACHE;
`else
            grant_c = ARB_M_DCACHE;
`endif
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
`endif

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares the AXI bridge request port between ICache and DCache.
// Optional round-robin conflict resolution via ARB_ROUND_ROBIN_EN.
module axi_req_arbiter
    import axi_req_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BLOCK_W = 256
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [REQ_W-1:0]   i_req,
    input  logic [ADDR_W-1:0]  i_ad,
    input  logic [2:0]         i_rword_en,
    output logic               i_done,
    output logic [BLOCK_W-1:0] i_rblock,
    output logic [DATA_W-1:0]  i_rword,

    input  logic [REQ_W-1:0]   d_req,
    input  logic [ADDR_W-1:0]  d_ad,
    input  logic [BLOCK_W-1:0] d_wblock,
    input  logic [DATA_W-1:0]  d_wword,
    input  logic [3:0]         d_wword_en,
    input  logic [2:0]         d_rword_en,
    output logic               d_done,
    output logic [BLOCK_W-1:0] d_rblock,
    output logic [DATA_W-1:0]  d_rword,

    output logic [REQ_W-1:0]   br_req,
    output logic [ADDR_W-1:0]  br_ad,
    output logic [BLOCK_W-1:0] br_wblock,
    output logic [DATA_W-1:0]  br_wword,
    output logic [3:0]         br_wword_en,
    output logic [2:0]         br_rword_en,
    input  logic               br_ready,
    input  logic               br_finish,
    input  logic [BLOCK_W-1:0] br_rblock,
    input  logic [DATA_W-1:0]  br_rword
);

    arb_state_t       state_q, state_d;
    arb_master_t      grant_q, grant_d;
    arb_master_t      sel_grant_c;
    arb_master_t      rr_last_c;
    logic             i_valid_c, d_valid_c;
    logic [REQ_W-1:0] br_req_d;
    logic             i_done_d, d_done_d;

    assign i_valid_c = icache_req_legal(i_req);
    assign d_valid_c = (d_req != REQ_TO_AXI_NONE);

    arb_grant_sel u_grant_sel (
        .i_valid (i_valid_c),
        .d_valid (d_valid_c),
        .rr_last (rr_last_c),
        .grant_c (sel_grant_c)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_master_t rr_last_q;

    // Remember the last winner so the other master wins the next conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= ARB_M_ICACHE;
        end else if ((state_q == ARB_IDLE) && (state_d == ARB_ISSUE)) begin
            rr_last_q <= grant_d;
        end
    end

    assign rr_last_c = rr_last_q;
`else
    assign rr_last_c = ARB_M_ICACHE;
`endif

    // Next-state, registered request code and done pulses.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        br_req_d = REQ_TO_AXI_NONE;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (br_ready && (i_valid_c || d_valid_c)) begin
                    grant_d  = sel_grant_c;
                    br_req_d = (sel_grant_c == ARB_M_ICACHE) ? i_req : d_req;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_d = ARB_BUSY;
            ARB_BUSY: begin
                if (br_finish) begin
                    i_done_d = (grant_q == ARB_M_ICACHE);
                    d_done_d = (grant_q == ARB_M_DCACHE);
                    state_d  = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= ARB_M_DCACHE;
            br_req   <= REQ_TO_AXI_NONE;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            i_rblock <= '0;
            i_rword  <= '0;
            d_rblock <= '0;
            d_rword  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            br_req  <= br_req_d;
            i_done  <= i_done_d;
            d_done  <= d_done_d;
            // Read data is held per master until that master's next completion.
            if (i_done_d) begin
                i_rblock <= br_rblock;
                i_rword  <= br_rword;
            end
            if (d_done_d) begin
                d_rblock <= br_rblock;
                d_rword  <= br_rword;
            end
        end
    end

    // Bridge samples write data a cycle after req, so payload follows the grant register.
    assign br_ad       = (grant_q == ARB_M_ICACHE) ? i_ad       : d_ad;
    assign br_rword_en = (grant_q == ARB_M_ICACHE) ? i_rword_en : d_rword_en;
    assign br_wblock   = (grant_q == ARB_M_ICACHE) ? '0         : d_wblock;
    assign br_wword    = (grant_q == ARB_M_ICACHE) ? '0         : d_wword;
    assign br_wword_en = (grant_q == ARB_M_ICACHE) ? 4'b0000    : d_wword_en;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Randomized bench for axi_req_arbiter against a transaction-level reference model.
module tb_axi_req_arbiter;
    import axi_req_arbiter_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BLOCK_W = 256;
    localparam int          N_CYC   = 4000;

    logic               clk = 1'b0;
    logic               rst;
    logic [REQ_W-1:0]   i_req;
    logic [ADDR_W-1:0]  i_ad;
    logic [2:0]         i_rword_en;
    logic               i_done;
    logic [BLOCK_W-1:0] i_rblock;
    logic [DATA_W-1:0]  i_rword;
    logic [REQ_W-1:0]   d_req;
    logic [ADDR_W-1:0]  d_ad;
    logic [BLOCK_W-1:0] d_wblock;
    logic [DATA_W-1:0]  d_wword;
    logic [3:0]         d_wword_en;
    logic [2:0]         d_rword_en;
    logic               d_done;
    logic [BLOCK_W-1:0] d_rblock;
    logic [DATA_W-1:0]  d_rword;
    logic [REQ_W-1:0]   br_req;
    logic [ADDR_W-1:0]  br_ad;
    logic [BLOCK_W-1:0] br_wblock;
    logic [DATA_W-1:0]  br_wword;
    logic [3:0]         br_wword_en;
    logic [2:0]         br_rword_en;
    logic               br_ready;
    logic               br_finish;
    logic [BLOCK_W-1:0] br_rblock;
    logic [DATA_W-1:0]  br_rword;

    axi_req_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_ad(i_ad), .i_rword_en(i_rword_en),
        .i_done(i_done), .i_rblock(i_rblock), .i_rword(i_rword),
        .d_req(d_req), .d_ad(d_ad), .d_wblock(d_wblock), .d_wword(d_wword),
        .d_wword_en(d_wword_en), .d_rword_en(d_rword_en),
        .d_done(d_done), .d_rblock(d_rblock), .d_rword(d_rword),
        .br_req(br_req), .br_ad(br_ad), .br_wblock(br_wblock), .br_wword(br_wword),
        .br_wword_en(br_wword_en), .br_rword_en(br_rword_en),
        .br_ready(br_ready), .br_finish(br_finish),
        .br_rblock(br_rblock), .br_rword(br_rword)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model state: one outstanding transaction, arbiter free again two cycles after finish.
    bit                 eng;
    int                 issue_cyc, fin_cyc, free_from;
    arb_master_t        last, win;
    logic [REQ_W-1:0]   exp_br_req;
    bit                 exp_idone, exp_ddone;
    logic [255:0]       exp_irb, exp_drb;
    logic [31:0]        exp_irw, exp_drw;
    logic [ADDR_W-1:0]  s_ad;
    logic [2:0]         s_ren;
    logic [BLOCK_W-1:0] s_wblock;
    logic [DATA_W-1:0]  s_wword;
    logic [3:0]         s_wen;

    // Requester state: 0 idle, 1 waiting for done, 2 holding an illegal code.
    int i_st, d_st, i_cnt, i_rel_cyc, d_rel_cyc;
    bit clr_req;
    bit iv, dv;
    int p;

    initial begin
        rst = 1'b1; i_req = REQ_TO_AXI_NONE; d_req = REQ_TO_AXI_NONE;
        i_ad = '0; i_rword_en = '0; d_ad = '0; d_wblock = '0; d_wword = '0;
        d_wword_en = '0; d_rword_en = '0; br_ready = 1'b0; br_finish = 1'b0;
        br_rblock = '0; br_rword = '0;
        eng = 0; issue_cyc = 0; fin_cyc = 0; free_from = 0;
        last = ARB_M_ICACHE; win = ARB_M_DCACHE;
        exp_br_req = REQ_TO_AXI_NONE; exp_idone = 0; exp_ddone = 0;
        exp_irb = '0; exp_drb = '0; exp_irw = '0; exp_drw = '0;
        s_ad = '0; s_ren = '0; s_wblock = '0; s_wword = '0; s_wen = '0;
        i_st = 0; d_st = 0; i_cnt = 0; i_rel_cyc = -1; d_rel_cyc = -1; clr_req = 0;

        for (int k = 0; k < N_CYC; k++) begin
            @(negedge clk);

            if (k >= 1) begin
                chk("br_req", 256'(br_req), 256'(exp_br_req));
                chk("i_done", 256'(i_done), 256'(exp_idone));
                chk("d_done", 256'(d_done), 256'(exp_ddone));
                chk("i_rblock", i_rblock, exp_irb);
                chk("i_rword", 256'(i_rword), 256'(exp_irw));
                chk("d_rblock", d_rblock, exp_drb);
                chk("d_rword", 256'(d_rword), 256'(exp_drw));
                if (eng && k >= issue_cyc) begin
                    chk("br_ad", 256'(br_ad), 256'(s_ad));
                    chk("br_rword_en", 256'(br_rword_en), 256'(s_ren));
                    if (win == ARB_M_DCACHE) begin
                        chk("br_wblock", br_wblock, s_wblock);
                        chk("br_wword", 256'(br_wword), 256'(s_wword));
                        chk("br_wword_en", 256'(br_wword_en), 256'(s_wen));
                    end
                end
            end

            // Requesters: light traffic first half, near-continuous second half.
            p = (k < N_CYC / 2) ? 5 : 14;
            if (clr_req) begin
                i_req = REQ_TO_AXI_NONE; d_req = REQ_TO_AXI_NONE;
                i_st = 0; d_st = 0; clr_req = 0;
            end else begin
                if (d_st == 1 && k == d_rel_cyc) begin
                    d_req = REQ_TO_AXI_NONE; d_st = 0;
                end else if (d_st == 0) begin
                    d_ad = $urandom; d_wblock = rand256(); d_wword = $urandom;
                    d_wword_en = 4'($urandom); d_rword_en = 3'($urandom);
                    if (int'($urandom_range(0, 15)) < p) begin
                        d_req = REQ_W'($urandom_range(1, 4)); d_st = 1;
                    end
                end
                if (i_st == 1 && k == i_rel_cyc) begin
                    i_req = REQ_TO_AXI_NONE; i_st = 0;
                end else if (i_st == 2) begin
                    i_cnt--;
                    if (i_cnt == 0) begin i_req = REQ_TO_AXI_NONE; i_st = 0; end
                end else if (i_st == 0) begin
                    i_ad = $urandom; i_rword_en = 3'($urandom);
                    if (int'($urandom_range(0, 15)) < p) begin
                        if ($urandom_range(0, 7) == 0) begin
                            i_req = REQ_W'($urandom_range(3, 4)); i_st = 2;
                            i_cnt = int'($urandom_range(1, 8));
                        end else begin
                            i_req = REQ_W'($urandom_range(1, 2)); i_st = 1;
                        end
                    end
                end
            end

            // Bridge and reset stimulus.
            br_ready  = ($urandom_range(0, 3) != 0);
            br_rblock = rand256();
            br_rword  = $urandom;
            br_finish = eng && (k == fin_cyc);
            rst = (k < 2) || (eng && k > issue_cyc && $urandom_range(0, 99) == 0);

            // Expected DUT behaviour for the next cycle given this cycle's inputs.
            iv = (i_req == REQ_TO_AXI_LOAD_WORD) || (i_req == REQ_TO_AXI_LOAD_BLOCK);
            dv = (d_req != REQ_TO_AXI_NONE);
            exp_br_req = REQ_TO_AXI_NONE; exp_idone = 0; exp_ddone = 0;
            if (rst) begin
                eng = 0; free_from = k + 1; last = ARB_M_ICACHE;
                exp_irb = '0; exp_drb = '0; exp_irw = '0; exp_drw = '0;
                clr_req = 1; i_rel_cyc = -1; d_rel_cyc = -1;
            end else if (eng && br_finish) begin
                if (win == ARB_M_ICACHE) begin
                    exp_idone = 1; exp_irb = br_rblock; exp_irw = br_rword; i_rel_cyc = k + 2;
                end else begin
                    exp_ddone = 1; exp_drb = br_rblock; exp_drw = br_rword; d_rel_cyc = k + 2;
                end
                eng = 0; free_from = k + 2;
            end else if (!eng && k >= free_from && br_ready && (iv || dv)) begin
                if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = (last == ARB_M_ICACHE) ? ARB_M_DCACHE : ARB_M_ICACHE;
`else
                    win = ARB_M_DCACHE;
`endif
                end else begin
                    win = iv ? ARB_M_ICACHE : ARB_M_DCACHE;
                end
                last = win;
                exp_br_req = (win == ARB_M_ICACHE) ? i_req : d_req;
                s_ad  = (win == ARB_M_ICACHE) ? i_ad : d_ad;
                s_ren = (win == ARB_M_ICACHE) ? i_rword_en : d_rword_en;
                s_wblock = d_wblock; s_wword = d_wword; s_wen = d_wword_en;
                eng = 1; issue_cyc = k + 1;
                fin_cyc = k + 1 + int'($urandom_range(1, 6));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
